// File: rtl/alu_pkg.sv
// Shared ALU control codes, default datapath width and execute-unit FSM states.
// Imported by the ALU decoder and the execute-stage arithmetic unit.
package alu_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 32;
    localparam int unsigned ALU_CTRL_W     = 4;

    typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = 4'b0000;
    localparam alu_ctrl_t ALU_SUB = 4'b0001;
    localparam alu_ctrl_t ALU_MUL = 4'b0010;
    localparam alu_ctrl_t ALU_SLT = 4'b0011;
    localparam alu_ctrl_t ALU_AND = 4'b0100;
    localparam alu_ctrl_t ALU_OR  = 4'b0101;
    localparam alu_ctrl_t ALU_XOR = 4'b0110;
    localparam alu_ctrl_t ALU_NOR = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: retires MUL_BITS_PER_CYCLE multiplier bits per cycle
// and raises a combinational done pulse together with the final low-half product.
module exec_mul_iter #(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] mcand_i,
    input  logic [DATA_WIDTH-1:0] mplier_i,
    output logic                  done_c_o,
    output logic [DATA_WIDTH-1:0] product_c_o
);

    localparam int unsigned STEPS = DATA_WIDTH / MUL_BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    logic                  run_q,    run_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] mcand_q,  mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_q,    acc_d;
    logic [DATA_WIDTH-1:0] partial_c;

    // Shifted multiplicand copies selected by the low multiplier bits of this step.
    always_comb begin
        partial_c = '0;
        for (int unsigned j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) begin
                partial_c = partial_c + (mcand_q << j);
            end
        end
    end

    assign product_c_o = acc_q + partial_c;
    assign done_c_o    = run_q && (cnt_q == LAST_STEP);

    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (abort_i) begin
            run_d = 1'b0;
            cnt_d = '0;
            acc_d = '0;
        end else if (start_i) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = '0;
        end else if (run_q) begin
            acc_d    = product_c_o;
            mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
            mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
            cnt_d    = cnt_q + CNT_W'(1);
            run_d    = !done_c_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/exec_alu_unit.sv
// Execute-stage arithmetic unit: single-cycle ALU ops plus an iterative multiply,
// with valid/ready handshakes on both sides and a held result until consumed.
module exec_alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = ALU_DATA_WIDTH,
    parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned MSB = DATA_WIDTH - 1;

    alu_state_e            state_q,  state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q,   zero_d;
    logic                  ovf_q,    ovf_d;

    logic                  accept_c;
    logic                  mul_start_c;
    logic                  mul_done_c;
    logic [DATA_WIDTH-1:0] mul_prod_c;
    logic [DATA_WIDTH-1:0] sum_c;
    logic [DATA_WIDTH-1:0] diff_c;
    logic [DATA_WIDTH-1:0] alu_res_c;
    logic                  alu_ovf_c;

    // Ready also depends on out_ready so a held result and a new op can transfer on one edge.
    assign in_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
    assign accept_c = in_valid && in_ready;

    assign sum_c  = src_a + src_b;
    assign diff_c = src_a - src_b;

    // Single-cycle datapath; unknown codes fall through to add, overflow included.
    always_comb begin
        alu_res_c = sum_c;
        alu_ovf_c = (src_a[MSB] == src_b[MSB]) && (sum_c[MSB] != src_a[MSB]);
        case (alu_ctrl)
            ALU_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = (src_a[MSB] != src_b[MSB]) && (diff_c[MSB] != src_a[MSB]);
            end
            ALU_SLT: begin
                alu_res_c = DATA_WIDTH'($signed(src_a) < $signed(src_b));
                alu_ovf_c = 1'b0;
            end
            ALU_AND: begin
                alu_res_c = src_a & src_b;
                alu_ovf_c = 1'b0;
            end
            ALU_OR: begin
                alu_res_c = src_a | src_b;
                alu_ovf_c = 1'b0;
            end
            ALU_XOR: begin
                alu_res_c = src_a ^ src_b;
                alu_ovf_c = 1'b0;
            end
            ALU_NOR: begin
                alu_res_c = ~(src_a | src_b);
                alu_ovf_c = 1'b0;
            end
            ALU_MUL: begin
                alu_res_c = '0;
                alu_ovf_c = 1'b0;
            end
            default: ;
        endcase
    end

    exec_mul_iter #(
        .DATA_WIDTH         (DATA_WIDTH),
        .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .start_i     (mul_start_c),
        .abort_i     (flush),
        .mcand_i     (src_a),
        .mplier_i    (src_b),
        .done_c_o    (mul_done_c),
        .product_c_o (mul_prod_c)
    );

    // Next-state logic; flush overrides any transition and any multiply start.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        mul_start_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if ((state_q == ST_HOLD) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept_c) begin
                    if (alu_ctrl == ALU_MUL) begin
                        mul_start_c = 1'b1;
                        state_d     = ST_MUL;
                    end else begin
                        result_d = alu_res_c;
                        ovf_d    = alu_ovf_c;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done_c) begin
                    result_d = mul_prod_c;
                    ovf_d    = 1'b0;
                    state_d  = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (result_d == '0);
        if (flush) begin
            state_d     = ST_IDLE;
            mul_start_c = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_MUL);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule
